// File: rtl/fifteen_line_pulse_decoder.sv
// Sequential 4-to-15 line decoder: each accepted code becomes a fixed-width one-hot pulse
// followed by an all-low gap. Optional one-entry pending buffer: FIFTEEN_LINE_DEC_PEND_BUF_EN.
module fifteen_line_pulse_decoder #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_code,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [14:0] lines,
    output logic        busy,
    output logic        done
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_cur_code;
    logic [3:0]       w_cur_code_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic [14:0]      r_lines;
    logic             r_busy;
    logic             r_done;
    logic             w_xfer;
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
    logic [3:0]       r_pend_code;
    logic [3:0]       w_pend_code_nxt;
    logic             r_pend_vld;
    logic             w_pend_vld_nxt;
`endif

    // Code 0 maps to no line; code k sets bit k-1.
    function automatic logic [14:0] f_onehot(input logic [3:0] code);
        logic [15:0] v;
        v = 16'd1 << code;
        return v[15:1];
    endfunction

    assign w_xfer   = in_valid && r_ready;
    assign in_ready = r_ready;
    assign lines    = r_lines;
    assign busy     = r_busy;
    assign done     = r_done;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_code_nxt = r_cur_code;
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
        w_pend_code_nxt = r_pend_code;
        w_pend_vld_nxt  = r_pend_vld;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt    = S_PULSE;
                    w_cnt_nxt      = PULSE_LD;
                    w_cur_code_nxt = in_code;
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
                if (w_xfer) begin
                    w_pend_code_nxt = in_code;
                    w_pend_vld_nxt  = 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (r_cnt == '0) begin
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
                    // A buffered code wins; otherwise a code arriving now skips the buffer.
                    if (r_pend_vld) begin
                        w_state_nxt    = S_PULSE;
                        w_cnt_nxt      = PULSE_LD;
                        w_cur_code_nxt = r_pend_code;
                        w_pend_vld_nxt = 1'b0;
                    end else if (w_xfer) begin
                        w_state_nxt    = S_PULSE;
                        w_cnt_nxt      = PULSE_LD;
                        w_cur_code_nxt = in_code;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
                    if (w_xfer) begin
                        w_pend_code_nxt = in_code;
                        w_pend_vld_nxt  = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
        w_ready_nxt = (w_state_nxt == S_IDLE) || !w_pend_vld_nxt;
`else
        w_ready_nxt = (w_state_nxt == S_IDLE);
`endif
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cur_code <= '0;
            r_ready    <= 1'b1;
            r_lines    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
            r_pend_code <= '0;
            r_pend_vld  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_code <= w_cur_code_nxt;
            r_ready    <= w_ready_nxt;
            r_lines    <= (w_state_nxt == S_PULSE) ? f_onehot(w_cur_code_nxt) : 15'd0;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (r_state == S_PULSE) && (w_state_nxt == S_GAP);
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
            r_pend_code <= w_pend_code_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifteen_line_pulse_decoder.sv
// Bench for fifteen_line_pulse_decoder: two instances (4/1 and 1/1 pulse/gap) against a slot-schedule model.
module tb_fifteen_line_pulse_decoder;

    localparam int PA = 4;
    localparam int GA = 1;
    localparam int PB = 1;
    localparam int GB = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_code;
    logic        in_valid;
    logic        ready_a, busy_a, done_a;
    logic [14:0] lines_a;
    logic        ready_b, busy_b, done_b;
    logic [14:0] lines_b;

    always #5 clk = ~clk;

    fifteen_line_pulse_decoder #(.PULSE_W(PA), .GAP_W(GA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(ready_a), .lines(lines_a), .busy(busy_a), .done(done_a)
    );

    fifteen_line_pulse_decoder #(.PULSE_W(PB), .GAP_W(GB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(ready_b), .lines(lines_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: each accepted code owns a slot starting at edge s; after edge e with k=e-s,
    // k<P is pulse, P<=k<P+G is gap (done at k==P), later is idle.
    int         m_p [2];
    int         m_g [2];
    int         m_ls[2];
    int         m_ps[2];
    logic [3:0] m_lc[2];
    logic [3:0] m_pc[2];
    int         m_acc_a;
    int         xa[$];
    logic [14:0] lb[$];

    function automatic logic [14:0] exp_line(input logic [3:0] c);
        int t;
        if (c == 4'd0) return 15'd0;
        t = 1 << (int'(c) - 1);
        return t[14:0];
    endfunction

    function automatic logic m_ready(input int d, input int e);
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
        return m_ls[d] <= e;
`else
        return e >= m_ls[d] + m_p[d] + m_g[d];
`endif
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_ls[d] = -100000;
            m_ps[d] = -100000;
            m_lc[d] = 4'd0;
            m_pc[d] = 4'd0;
        end
    endtask

    task automatic m_accept(input int d, input int e, input logic [3:0] c);
        int s;
        s = e;
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
        if (m_ls[d] + m_p[d] + m_g[d] > s) s = m_ls[d] + m_p[d] + m_g[d];
`endif
        m_ps[d] = m_ls[d];
        m_pc[d] = m_lc[d];
        m_ls[d] = s;
        m_lc[d] = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string n, input int d, input logic [14:0] l,
                             input logic b, input logic dn, input logic r);
        int s, k;
        logic [3:0]  c;
        logic [14:0] el;
        logic        eb, ed;
        if (m_ls[d] <= cyc) begin s = m_ls[d]; c = m_lc[d]; end
        else begin s = m_ps[d]; c = m_pc[d]; end
        k = cyc - s;
        el = 15'd0; eb = 1'b0; ed = 1'b0;
        if (k < m_p[d]) begin
            el = exp_line(c);
            eb = 1'b1;
        end else if (k < m_p[d] + m_g[d]) begin
            eb = 1'b1;
            ed = (k == m_p[d]);
        end
        chk({n, "_lines"}, 32'(l), 32'(el));
        chk({n, "_busy"}, 32'(b), 32'(eb));
        chk({n, "_done"}, 32'(dn), 32'(ed));
        chk({n, "_ready"}, 32'(r), 32'(m_ready(d, cyc)));
        chk({n, "_onehot"}, 32'($countones(l) <= 1), 32'd1);
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        logic acc [2];
        in_valid = v;
        in_code  = c;
        for (int d = 0; d < 2; d++) acc[d] = v && m_ready(d, cyc);
        if (v && ready_a) xa.push_back(cyc + 1);
        if (acc[0]) m_acc_a++;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) if (acc[d]) m_accept(d, cyc, c);
        #1;
        check_one("a", 0, lines_a, busy_a, done_a, ready_a);
        check_one("b", 1, lines_b, busy_b, done_b, ready_b);
    endtask

    task automatic send(input logic [3:0] c);
        int n;
        n = 0;
        while (!m_ready(0, cyc) && n < 100) begin
            step(1'b0, 4'($urandom_range(0, 15)));
            n++;
        end
        checks++;
        assert (n < 100) else begin
            failures++;
            $error("FAIL send_timeout observed=%0d expected<100", n);
        end
        step(1'b1, c);
    endtask

    task automatic wait_idle();
        repeat (12) step(1'b0, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] exp_seq[$];
        int qi, n;
        logic [3:0] q[3];

        m_p[0] = PA; m_g[0] = GA;
        m_p[1] = PB; m_g[1] = GB;
        m_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_code = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lines_a", 32'(lines_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_lines_b", 32'(lines_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        #1;
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        step(1'b0, 4'd0);

        // Single code 1 through a full slot
        send(4'd1);
        repeat (7) step(1'b0, 4'd0);

        // Code 15 then code 0 (slot consumed with no line)
        send(4'd15);
        send(4'd0);
        repeat (8) step(1'b0, 4'd0);

        // Sweep all codes, in_code wandering while valid is low
        for (int k = 1; k < 16; k++) begin
            send(4'(k));
            repeat (2) step(1'b0, 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-pulse
        wait_idle();
        send(4'd11);
        step(1'b0, 4'd0);
        chk("pre_reset_lines_a", 32'(lines_a), 32'h400);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lines_a", 32'(lines_a), 32'd0);
        chk("mid_rst_busy_a", 32'(busy_a), 32'd0);
        chk("mid_rst_done_a", 32'(done_a), 32'd0);
        chk("mid_rst_lines_b", 32'(lines_b), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        #1;
        chk("post_rst_ready_a", 32'(ready_a), 32'd1);
        chk("post_rst_ready_b", 32'(ready_b), 32'd1);

        // Backpressure: hold code 7 valid
        wait_idle();
        xa.delete();
        m_acc_a = 0;
        repeat (18) step(1'b1, 4'd7);
        chk("bp_count_model", 32'(xa.size()), 32'(m_acc_a));
`ifndef FIFTEEN_LINE_DEC_PEND_BUF_EN
        chk("bp_count", 32'(xa.size()), 32'd3);
        for (int i = 1; i < xa.size(); i++) chk("bp_spacing", 32'(xa[i] - xa[i-1]), 32'd6);
`endif

        // Randomized traffic
        wait_idle();
        repeat (300) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        // Codes 3, 5, 9 presented continuously, observed on the 1/1 instance
        wait_idle();
        q[0] = 4'd3; q[1] = 4'd5; q[2] = 4'd9;
        lb.delete();
        qi = 0;
        n = 0;
        while (qi < 3 && n < 20) begin
            logic acc;
            acc = m_ready(1, cyc);
            step(1'b1, q[qi]);
            lb.push_back(lines_b);
            if (acc) qi++;
            n++;
        end
        repeat (4) begin
            step(1'b0, 4'd0);
            lb.push_back(lines_b);
        end
`ifdef FIFTEEN_LINE_DEC_PEND_BUF_EN
        exp_seq = '{15'h004, 15'h000, 15'h010, 15'h000, 15'h100};
`else
        exp_seq = '{15'h004, 15'h000, 15'h000, 15'h010, 15'h000, 15'h000, 15'h100};
`endif
        chk("seq_len_ok", 32'(lb.size() >= exp_seq.size()), 32'd1);
        for (int i = 0; i < exp_seq.size() && i < lb.size(); i++)
            chk($sformatf("seq_lines_%0d", i), 32'(lb[i]), 32'(exp_seq[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
